arb_requester: RTL and testbench
================================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter N, default 4: number of requester channels, equal to arbiter width.
REQ-002 Parameter LEN_W, default 4: burst-length field width per channel.
REQ-003 Parameter TIMEOUT, default 64: consecutive ungranted request cycles before starvation flag; range 2..2^16-1.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  N  per-channel burst launch strobe, one cycle.
REQ-007 len  input  N*LEN_W  packed burst lengths; channel i in bits [i*LEN_W +: LEN_W]; sampled with start[i].
REQ-008 grant  input  N  one-hot grant from registered fixed-priority arbiter; lags req by one cycle.
REQ-009 req  output  N  per-channel request to arbiter, registered.
REQ-010 beat  output  N  per-channel transfer beat, combinational from registered state and grant.
REQ-011 done  output  N  per-channel burst-complete pulse, registered, one cycle.
REQ-012 busy  output  N  per-channel burst in progress, registered.
REQ-013 starved  output  N  per-channel sticky starvation flag, registered.
REQ-014 grant_err  output  1  registered one-cycle pulse on illegal grant.

Function
REQ-015 Each channel SHALL run an independent FSM with states IDLE, REQ, DRAIN.
REQ-016 IDLE: start[i]=1 -> REQ next cycle; rem[i] loaded with len[i], len 0 meaning 2^LEN_W beats; busy[i]=1, req[i]=1 from that cycle.
REQ-017 start[i] in REQ or DRAIN SHALL be ignored; no queuing.
REQ-018 beat[i] SHALL equal grant[i] AND req[i] AND grant legal (REQ-024); a granted cycle with req[i]=0 SHALL NOT count as a beat.
REQ-019 Each beat SHALL decrement rem[i]; grant gaps (preemption by higher channel) SHALL hold rem[i] and req[i].
REQ-020 Beat with rem[i]=1: next cycle req[i]=0, state DRAIN, done[i]=1 for that one cycle.
REQ-021 DRAIN: lasts exactly one cycle to absorb the lagging arbiter grant, then IDLE with busy[i]=0; start[i] accepted again from IDLE only, earliest 2 cycles after last beat.
REQ-022 Starvation: per-channel wait counter increments each REQ cycle with grant[i]=0, clears on any beat; at count reaching TIMEOUT starved[i] set next cycle, counter saturates.
REQ-023 starved[i] SHALL clear only when a new start[i] is accepted in IDLE or on reset; wait counter also clears on start acceptance.
REQ-024 Grant legal iff zero or one bit set; more than one bit set -> grant_err=1 next cycle, no beat on any channel, no rem/wait change that cycle (wait counters still increment).
REQ-025 Grant to a channel in IDLE or DRAIN is not an error; silently ignored.
REQ-026 All channels SHALL advance concurrently; simultaneous starts on several channels are all accepted.
REQ-027 Counter widths: rem LEN_W+1 bits, wait counter 16 bits; no wrap permitted.

Reset
REQ-028 rst=1 at a clock edge SHALL force all FSMs to IDLE and req, done, busy, starved, grant_err, rem, wait counters to 0, overriding start and grant that cycle.
REQ-029 Reset mid-burst SHALL abort without done pulse; beat SHALL be 0 in the cycle after reset since req=0.

Verification
REQ-030 start[0]=1, len0=3, grant follows req with 1-cycle lag -> req[0] high 4 cycles, beat[0] 3 cycles, done[0] one cycle after 3rd beat, busy[0] low 2 cycles after last beat.
REQ-031 ch0 len 4 running, ch3 started after 2nd beat, arbiter preempts -> ch0 beats pause while ch3 bursts, ch0 resumes, total 4 beats, rem held during gap.
REQ-032 ch1 req held, grant=0 for 64 cycles, TIMEOUT=64 -> starved[1]=1 after 64th ungranted cycle, stays 1 after burst completes, clears on next accepted start.
REQ-033 grant=4'b0110 injected while ch1, ch2 requesting -> grant_err pulse, no beats, rem unchanged.
REQ-034 len=0 -> exactly 16 beats, then done; start during burst ignored; rst mid-burst -> all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/arb_requester.sv
// -----------------------------------------------------------------------------
// arb_requester
//
// Purpose:
//    A bank of N independent burst requesters that sit in front of a registered
//    fixed-priority arbiter. Each channel accepts a one-cycle launch strobe with
//    a burst length. It then requests the arbiter until that many beats have
//    been granted. Finally it spends one drain cycle so that the arbiter's
//    lagging grant is absorbed. The block also flags channels that wait too
//    long (sticky starvation) and reports grants that have more than one bit set.
//
// Ports:
//    clk        in   1        clock, rising edge
//    rst        in   1        synchronous active-high reset
//    start      in   N        per-channel burst launch strobe
//    len        in   N*LEN_W  packed burst lengths, channel i at [i*LEN_W +: LEN_W]
//                             (0 encodes 2^LEN_W beats)
//    grant      in   N        one-hot grant from arbiter, one cycle behind req
//    req        out  N        registered per-channel request
//    beat       out  N        combinational transfer beat
//    done       out  N        registered one-cycle burst-complete pulse
//    busy       out  N        registered burst-in-progress flag
//    starved    out  N        registered sticky starvation flag
//    grant_err  out  1        registered one-cycle pulse on a multi-bit grant
// -----------------------------------------------------------------------------
module arb_requester #(
   parameter int N       = 4,
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         start,
   input  logic [N*LEN_W-1:0]   len,
   input  logic [N-1:0]         grant,
   output logic [N-1:0]         req,
   output logic [N-1:0]         beat,
   output logic [N-1:0]         done,
   output logic [N-1:0]         busy,
   output logic [N-1:0]         starved,
   output logic                 grant_err
);

   localparam int REM_W  = LEN_W + 1;
   localparam int WAIT_W = 16;
   localparam logic [WAIT_W-1:0] TIMEOUT_C    = WAIT_W'(TIMEOUT);
   localparam logic [WAIT_W-1:0] TIMEOUT_M1_C = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // A grant is usable only if at most one bit is set. Clearing the lowest
   // set bit leaves zero exactly in that case.
   logic grant_legal;
   assign grant_legal = ((grant & (grant - N'(1))) == '0);

   logic grant_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_err_q <= 1'b0;
      end else begin
         grant_err_q <= ~grant_legal;
      end
   end

   assign grant_err = grant_err_q;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         state_t              state_q, state_d;
         logic [REM_W-1:0]    rem_q, rem_d;
         logic [WAIT_W-1:0]   wait_q, wait_d;
         logic                req_q, req_d;
         logic                done_q, done_d;
         logic                busy_q, busy_d;
         logic                starved_q, starved_d;
         logic                beat_w;
         logic [LEN_W-1:0]    len_w;

         assign len_w  = len[gi*LEN_W +: LEN_W];
         // Because req_q is low in IDLE and DRAIN, a grant that arrives in
         // those states is ignored without any further decoding.
         assign beat_w = grant[gi] & req_q & grant_legal;

         always_ff @(posedge clk) begin
            if (rst) begin
               state_q   <= ST_IDLE;
               rem_q     <= '0;
               wait_q    <= '0;
               req_q     <= 1'b0;
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               starved_q <= 1'b0;
            end else begin
               state_q   <= state_d;
               rem_q     <= rem_d;
               wait_q    <= wait_d;
               req_q     <= req_d;
               done_q    <= done_d;
               busy_q    <= busy_d;
               starved_q <= starved_d;
            end
         end

         always_comb begin
            state_d   = state_q;
            rem_d     = rem_q;
            wait_d    = wait_q;
            req_d     = req_q;
            done_d    = 1'b0;
            busy_d    = busy_q;
            starved_d = starved_q;

            case (state_q)
               ST_IDLE: begin
                  if (start[gi]) begin
                     state_d   = ST_REQ;
                     rem_d     = (len_w == '0) ? (REM_W'(1) << LEN_W)
                                               : {1'b0, len_w};
                     req_d     = 1'b1;
                     busy_d    = 1'b1;
                     wait_d    = '0;
                     starved_d = 1'b0;
                  end
               end

               ST_REQ: begin
                  if (beat_w) begin
                     wait_d = '0;
                     rem_d  = rem_q - REM_W'(1);
                     if (rem_q == REM_W'(1)) begin
                        state_d = ST_DRAIN;
                        req_d   = 1'b0;
                        done_d  = 1'b1;
                     end
                  end else begin
                     // Any request cycle without a beat counts as waiting.
                     // This includes a cycle with an illegal multi-bit grant.
                     // The counter stops at TIMEOUT. The flag rises on the
                     // same edge as the counter reaches TIMEOUT.
                     if (wait_q != TIMEOUT_C) begin
                        wait_d = wait_q + WAIT_W'(1);
                     end
                     if (wait_q >= TIMEOUT_M1_C) begin
                        starved_d = 1'b1;
                     end
                  end
               end

               ST_DRAIN: begin
                  // One cycle here is enough to swallow the grant that the
                  // arbiter issues in response to the final request cycle.
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end

               default: begin
                  state_d = ST_IDLE;
                  req_d   = 1'b0;
                  busy_d  = 1'b0;
               end
            endcase
         end

         assign req[gi]     = req_q;
         assign beat[gi]    = beat_w;
         assign done[gi]    = done_q;
         assign busy[gi]    = busy_q;
         assign starved[gi] = starved_q;
      end
   endgenerate

endmodule

// File: tb/tb_arb_requester.sv
// -----------------------------------------------------------------------------
// tb_arb_requester
//
// Purpose:
//    Self-checking bench for arb_requester with N=4, LEN_W=4 and TIMEOUT=64.
//    It first runs directed scenarios and then a randomized run.
//    A behavioural model keeps, for each channel, the number of beats still
//    owed, a one-cycle completion tail, and the wait count. Every cycle the
//    bench compares all DUT outputs against that model. It also emulates the
//    registered highest-index-wins arbiter, or it forces a grant value.
// -----------------------------------------------------------------------------
module tb_arb_requester;

   localparam int N       = 4;
   localparam int LEN_W   = 4;
   localparam int TIMEOUT = 64;

   logic                 clk;
   logic                 rst;
   logic [N-1:0]         start;
   logic [N*LEN_W-1:0]   len;
   logic [N-1:0]         grant;
   logic [N-1:0]         req;
   logic [N-1:0]         beat;
   logic [N-1:0]         done;
   logic [N-1:0]         busy;
   logic [N-1:0]         starved;
   logic                 grant_err;

   arb_requester #(.N(N), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .grant     (grant),
      .req       (req),
      .beat      (beat),
      .done      (done),
      .busy      (busy),
      .starved   (starved),
      .grant_err (grant_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model state for each channel: beats still owed (0 means not requesting),
   // a completion tail (1 in the done cycle), wait count and starvation flag.
   int           m_left[N];
   int           m_tail[N];
   int           m_wait[N];
   bit           m_starved[N];
   bit           m_gerr;
   logic [N-1:0] arb_g;
   int           beat_cnt[N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N*LEN_W-1:0] mk_len(input int ch, input int v);
      logic [N*LEN_W-1:0] r;
      r = '0;
      r[ch*LEN_W +: LEN_W] = LEN_W'(v);
      return r;
   endfunction

   // One clock cycle. The step drives the inputs, checks the outputs against
   // the model, advances the model, and then waits for the clock edge.
   task automatic step(input bit r, input logic [N-1:0] st, input logic [N*LEN_W-1:0] ln,
                       input bit force_g, input logic [N-1:0] g);
      logic [N-1:0] gnt, e_req, e_busy, e_done, e_starv, e_beat;
      bit           legal;
      int           lv;
      gnt   = force_g ? g : arb_g;
      rst   = r;
      start = st;
      len   = ln;
      grant = gnt;
      #1;
      for (int i = 0; i < N; i++) begin
         e_req[i]   = (m_left[i] > 0);
         e_busy[i]  = (m_left[i] > 0) || (m_tail[i] == 1);
         e_done[i]  = (m_tail[i] == 1);
         e_starv[i] = m_starved[i];
      end
      legal  = ($countones(gnt) <= 1);
      e_beat = e_req & gnt & {N{legal}};
      chk("req", req, e_req);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("starved", starved, e_starv);
      chk("grant_err", grant_err, m_gerr);
      chk("beat", beat, e_beat);
      for (int i = 0; i < N; i++) begin
         if (beat[i] === 1'b1) beat_cnt[i]++;
      end
      // The arbiter registers its pick, and the highest requesting index wins.
      arb_g = '0;
      for (int i = 0; i < N; i++) begin
         if (e_req[i]) begin
            arb_g    = '0;
            arb_g[i] = 1'b1;
         end
      end
      if (r) begin
         for (int i = 0; i < N; i++) begin
            m_left[i] = 0; m_tail[i] = 0; m_wait[i] = 0; m_starved[i] = 0;
         end
         m_gerr = 0;
      end else begin
         m_gerr = !legal;
         for (int i = 0; i < N; i++) begin
            if (!e_busy[i]) begin
               if (st[i]) begin
                  lv           = int'(ln[i*LEN_W +: LEN_W]);
                  m_left[i]    = (lv == 0) ? (1 << LEN_W) : lv;
                  m_wait[i]    = 0;
                  m_starved[i] = 0;
                  m_tail[i]    = 0;
               end
            end else if (e_req[i]) begin
               if (e_beat[i]) begin
                  m_left[i]--;
                  m_wait[i] = 0;
                  if (m_left[i] == 0) m_tail[i] = 1;
               end else begin
                  if (m_wait[i] < TIMEOUT) m_wait[i]++;
                  if (m_wait[i] >= TIMEOUT) m_starved[i] = 1;
               end
            end else begin
               m_tail[i] = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clr_cnt();
      for (int i = 0; i < N; i++) beat_cnt[i] = 0;
   endtask

   task automatic idle_steps(input int n);
      for (int k = 0; k < n; k++) step(0, '0, '0, 0, '0);
   endtask

   initial begin
      logic [N-1:0]       r_st;
      logic [N*LEN_W-1:0] r_ln;
      logic [N-1:0]       r_g;
      int                 mode;
      int                 k;

      rst = 1'b1; start = '0; len = '0; grant = '0;
      arb_g = '0; m_gerr = 0;
      for (int i = 0; i < N; i++) begin
         m_left[i] = 0; m_tail[i] = 0; m_wait[i] = 0; m_starved[i] = 0;
      end
      clr_cnt();
      @(posedge clk);
      #1;

      // Reset state.
      step(1, '0, '0, 1, '0);
      step(1, 4'b1111, '1, 1, 4'b1111);
      chk("rst_req", req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gerr", grant_err, 0);

      // A three-beat burst on channel 0 with the arbiter following.
      clr_cnt();
      step(0, 4'b0001, mk_len(0, 3), 0, '0);
      idle_steps(8);
      chk("len3_beats", beat_cnt[0], 3);

      // Channel 3 preempts channel 0 in the middle of a burst.
      clr_cnt();
      step(0, 4'b0001, mk_len(0, 4), 0, '0);
      k = 0;
      while (beat_cnt[0] < 1 && k < 10) begin
         step(0, '0, '0, 0, '0);
         k++;
      end
      chk("pre_first_beat", beat_cnt[0], 1);
      step(0, 4'b1000, mk_len(3, 2), 0, '0);
      chk("pre_second_beat", beat_cnt[0], 2);
      idle_steps(15);
      chk("pre_ch0_beats", beat_cnt[0], 4);
      chk("pre_ch3_beats", beat_cnt[3], 2);

      // Starvation on channel 1 after 64 ungranted request cycles.
      step(0, 4'b0010, mk_len(1, 2), 1, '0);
      for (int j = 0; j < TIMEOUT - 1; j++) step(0, '0, '0, 1, '0);
      chk("starve_before", starved[1], 0);
      step(0, '0, '0, 1, '0);
      chk("starve_set", starved[1], 1);
      idle_steps(8);
      chk("starve_sticky", starved[1], 1);
      chk("starve_idle", busy[1], 0);
      step(0, 4'b0010, mk_len(1, 1), 0, '0);
      chk("starve_clear", starved[1], 0);
      idle_steps(6);

      // Illegal grant while channels 1 and 2 are requesting.
      clr_cnt();
      step(0, 4'b0110, mk_len(1, 5) | mk_len(2, 5), 1, '0);
      step(0, '0, '0, 1, '0);
      step(0, '0, '0, 1, 4'b0110);
      chk("gerr_pulse", grant_err, 1);
      idle_steps(25);
      chk("gerr_ch1_beats", beat_cnt[1], 5);
      chk("gerr_ch2_beats", beat_cnt[2], 5);

      // len=0 means 16 beats. A start during the burst is ignored.
      clr_cnt();
      step(0, 4'b0100, mk_len(2, 0), 0, '0);
      idle_steps(3);
      step(0, 4'b0100, mk_len(2, 5), 0, '0);
      idle_steps(25);
      chk("len0_beats", beat_cnt[2], 16);

      // Reset in the middle of a burst aborts the burst with no done pulse.
      clr_cnt();
      step(0, 4'b0001, mk_len(0, 0), 0, '0);
      idle_steps(5);
      step(1, '0, '0, 0, '0);
      chk("abort_req", req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_beat", beat, 0);
      idle_steps(4);

      // Randomized traffic.
      for (int c = 0; c < 2000; c++) begin
         r_st = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
         r_ln = (N*LEN_W)'($urandom);
         mode = $urandom_range(0, 9);
         r_g  = N'($urandom_range(0, 15));
         if (mode < 8)
            step($urandom_range(0, 199) == 0, r_st, r_ln, 0, '0);
         else if (mode == 8)
            step(0, r_st, r_ln, 1, r_g);
         else
            step(0, r_st, r_ln, 1, '0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
